// File: rtl/div_seq_ctrl_if.sv
// Handshake bundle between the EX-stage glue and the divide sequencer.
//   master : EX-stage side. It drives start, signed_div, opa, opb and flush, and
//            receives stall_div, busy, result_valid, hi_o and lo_o.
//   slave  : divider side, with the opposite directions.
interface div_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             flush;
  logic             stall_div;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start, signed_div, opa, opb, flush,
    input  stall_div, busy, result_valid, hi_o, lo_o
  );

  modport slave (
    input  start, signed_div, opa, opb, flush,
    output stall_div, busy, result_valid, hi_o, lo_o
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage: radix-2 restoring division,
// one iteration per cycle over WIDTH iterations. It holds the pipeline while it
// works and issues a single HI/LO write pulse when it finishes.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_seq_ctrl_if.slave
//          in  : start, signed_div, opa, opb, flush
//          out : stall_div (comb), busy (reg), result_valid (reg pulse, flush-gated),
//                hi_o = remainder, lo_o = quotient
module div_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  div_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StZero, StOn, StEnd} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, hi_q, lo_q;
  logic             quo_neg_q, rem_neg_q, busy_q, rv_q;
  logic             stall_div;

  logic             accept, last_step, zero_dvs;
  logic [WIDTH-1:0] abs_a, abs_b, rem_nx, quo_nx;
  logic [WIDTH:0]   rem_sh, trial;

  assign accept    = bus.start & ~bus.flush;
  assign zero_dvs  = (bus.opb == '0);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign abs_a     = (bus.signed_div & bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
  assign abs_b     = (bus.signed_div & bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;

  // One restoring step: shift {rem,quo} left, trial-subtract, keep on non-negative.
  // rem_q < dvs_q always holds, so the (WIDTH+1)-bit trial never overflows.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = zero_dvs ? StZero : StOn;
      StZero:  state_d = StEnd;
      StOn:    if (last_step) state_d = StEnd;
      StEnd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) begin
      state_d = StIdle;
    end
  end

  // Output logic: stall is low in END so the pipeline advances with the HI/LO write
  always_comb begin
    stall_div = 1'b0;
    unique case (state_q)
      StIdle:      stall_div = bus.start;
      StZero, StOn: stall_div = 1'b1;
      default:     stall_div = 1'b0;
    endcase
    if (bus.flush) begin
      stall_div = 1'b0;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      busy_q <= (state_d == StZero) || (state_d == StOn);
      rv_q   <= (state_d == StEnd);
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= abs_b;
            // Divide-by-zero keeps the raw dividend to return it as HI.
            quo_q     <= zero_dvs ? bus.opa : abs_a;
            quo_neg_q <= bus.signed_div & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
            rem_neg_q <= bus.signed_div & bus.opa[WIDTH-1];
          end
        end
        StZero: begin
          if (!bus.flush) begin
            hi_q <= quo_q;
            lo_q <= '1;
          end
        end
        StOn: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_step && !bus.flush) begin
            hi_q <= rem_neg_q ? -rem_nx : rem_nx;
            lo_q <= quo_neg_q ? -quo_nx : quo_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_div    = stall_div;
  assign bus.busy         = busy_q;
  // A flush landing in END still kills the write pulse.
  assign bus.result_valid = rv_q & ~bus.flush;
  assign bus.hi_o         = hi_q;
  assign bus.lo_o         = lo_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  div_seq_ctrl_if #(.WIDTH(32)) bus ();

  div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics from plain arithmetic.
  task automatic model(input bit sd, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      lat = 2;
    end else begin
      lat = 33;
      if (sd && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = 32'h8000_0000;
        hi = 32'd0;
      end else if (sd) begin
        lo = sa / sb;
        hi = sa % sb;
      end else begin
        lo = a / b;
        hi = a % b;
      end
    end
  endtask

  // Issue one divide and follow it to its pulse. Operands are scrambled after
  // acceptance to show they were captured. keep_start leaves start high.
  task automatic run_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                         input bit keep_start);
    logic [31:0] ehi, elo;
    int          lat, got;
    bit          done;
    model(sd, a, b, ehi, elo, lat);
    @(posedge clk) #1;
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.opa        = a;
    bus.opb        = b;
    got  = -1;
    done = 1'b0;
    for (int k = 0; k <= 80 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.opa        = $urandom;
        bus.opb        = $urandom;
        bus.signed_div = ~sd;
      end
      chk($sformatf("stall k=%0d", k), {31'd0, bus.stall_div}, {31'd0, k < lat});
      if (bus.result_valid) begin
        got  = k;
        done = 1'b1;
        chk("hi", bus.hi_o, ehi);
        chk("lo", bus.lo_o, elo);
      end
    end
    chk($sformatf("latency a=%h b=%h sd=%0d", a, b, sd), got, lat);
    if (!keep_start) bus.start = 1'b0;
  endtask

  // Start a divide and flush it n cycles after acceptance.
  task automatic flush_at(input logic [31:0] a, input logic [31:0] b, input int n);
    bit seen;
    @(posedge clk) #1;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opa        = a;
    bus.opb        = b;
    repeat (n) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    chk($sformatf("flush%0d stall", n), {31'd0, bus.stall_div}, 32'd0);
    chk($sformatf("flush%0d rv", n), {31'd0, bus.result_valid}, 32'd0);
    @(posedge clk) #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk($sformatf("flush%0d busy", n), {31'd0, bus.busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.result_valid) seen = 1'b1;
    end
    chk($sformatf("flush%0d no pulse", n), {31'd0, seen}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rsd;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opa        = '0;
    bus.opb        = '0;
    bus.flush      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst rv", {31'd0, bus.result_valid}, 32'd0);
    chk("rst stall", {31'd0, bus.stall_div}, 32'd0);
    chk("rst hi", bus.hi_o, 32'd0);
    chk("rst lo", bus.lo_o, 32'd0);
    @(posedge clk) #1 rst = 1'b0;

    // Directed cases
    run_div(1'b0, 32'd7, 32'd2, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_div(1'b1, 32'h0000_1234, 32'd0, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush mid-divide and in the END cycle
    flush_at(32'd1000, 32'd3, 10);
    flush_at(32'd1000, 32'd3, 33);
    flush_at(32'd1000, 32'd0, 1);

    // Back-to-back with start held through END
    run_div(1'b0, 32'd100, 32'd7, 1'b1);
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0);

    // Randomised operands with corner values mixed in
    for (int i = 0; i < 16; i++) begin
      rsd = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_div(rsd, ra, rb, 1'($urandom_range(0, 1)));
    end
    bus.start = 1'b0;

    // Reset in the middle of a divide
    @(posedge clk) #1;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opa        = 32'hDEAD_BEEF;
    bus.opb        = 32'd5;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk) #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("midrst busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst rv", {31'd0, bus.result_valid}, 32'd0);
    chk("midrst stall", {31'd0, bus.stall_div}, 32'd0);
    chk("midrst hi", bus.hi_o, 32'd0);
    chk("midrst lo", bus.lo_o, 32'd0);

    // Still functional after the abort
    run_div(1'b0, 32'd100, 32'd7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
